// File: rtl/write_arbiter_wrr_if.sv
// Port bundle between the per-port write buffers (master) and the write arbiter (slave).
// The in_last field exists only when WRITE_ARB_PKT_LOCK_EN is defined.
interface write_arbiter_wrr_if #(
    parameter int DATA_W    = 256,
    parameter int NUM_PORTS = 16,
    parameter int WEIGHT_W  = 4,
    parameter int PORT_ID_W = $clog2(NUM_PORTS)
);
    logic                          sp0_wrr1;
    logic [NUM_PORTS-1:0]          req;
    logic [DATA_W*NUM_PORTS-1:0]   data_in_p;
    logic [WEIGHT_W*NUM_PORTS-1:0] weight_cfg;
    logic [NUM_PORTS-1:0]          gnt;
    logic [DATA_W-1:0]             data_out;
    logic                          out_valid;
    logic                          out_ready;
    logic [PORT_ID_W-1:0]          out_port;
`ifdef WRITE_ARB_PKT_LOCK_EN
    logic [NUM_PORTS-1:0]          in_last;
`endif

    modport master (
        output sp0_wrr1, req, data_in_p, weight_cfg, out_ready,
`ifdef WRITE_ARB_PKT_LOCK_EN
        output in_last,
`endif
        input  gnt, data_out, out_valid, out_port
    );

    modport slave (
        input  sp0_wrr1, req, data_in_p, weight_cfg, out_ready,
`ifdef WRITE_ARB_PKT_LOCK_EN
        input  in_last,
`endif
        output gnt, data_out, out_valid, out_port
    );
endinterface

// File: rtl/write_arbiter_wrr.sv
// N-port write arbiter: strict priority or weighted round robin, registered valid/ready output.
// Optional packet lock (per-port in_last) enabled by WRITE_ARB_PKT_LOCK_EN.
module write_arbiter_wrr #(
    parameter int DATA_W    = 256,
    parameter int NUM_PORTS = 16,
    parameter int WEIGHT_W  = 4,
    parameter int PORT_ID_W = $clog2(NUM_PORTS)
) (
    input logic                clk,
    input logic                rst,
    write_arbiter_wrr_if.slave bus
);
    typedef enum logic {MODE_SP = 1'b0, MODE_WRR = 1'b1} mode_e;

    logic [PORT_ID_W-1:0] rr_ptr;
    logic [WEIGHT_W-1:0]  credit;
    mode_e                mode_q;
    logic [DATA_W-1:0]    data_q;
    logic                 valid_q;
    logic [PORT_ID_W-1:0] port_q;
`ifdef WRITE_ARB_PKT_LOCK_EN
    logic                 locked;
    logic [PORT_ID_W-1:0] lock_port;
`endif

    mode_e                mode_cur, mode_eff;
    logic                 load, take, retain, mode_chg, win_ok;
    logic [WEIGHT_W-1:0]  credit_eff, win_weight, new_credit;
    logic [PORT_ID_W-1:0] sp_idx, srch_idx, win_idx;
    logic [DATA_W-1:0]    sel_data;
    logic [31:0]          p;

    always_comb begin
        mode_cur = mode_e'(bus.sp0_wrr1);
`ifdef WRITE_ARB_PKT_LOCK_EN
        // a locked packet keeps the mode it started in; the switch is seen after unlock
        mode_eff = locked ? mode_q : mode_cur;
        mode_chg = ~locked & (mode_cur != mode_q);
`else
        mode_eff = mode_cur;
        mode_chg = (mode_cur != mode_q);
`endif
        credit_eff = mode_chg ? '0 : credit;
        load       = ~valid_q | bus.out_ready;

        sp_idx = '0;
        for (int unsigned i = NUM_PORTS; i > 0; i--)
            if (bus.req[PORT_ID_W'(i - 1)]) sp_idx = PORT_ID_W'(i - 1);

        // scan from farthest to nearest so the nearest requester after rr_ptr wins;
        // distance NUM_PORTS lands back on rr_ptr itself
        p        = '0;
        srch_idx = rr_ptr;
        for (int unsigned k = NUM_PORTS; k > 0; k--) begin
            p = 32'(rr_ptr) + k;
            if (p >= 32'(NUM_PORTS)) p = p - 32'(NUM_PORTS);
            if (bus.req[PORT_ID_W'(p)]) srch_idx = PORT_ID_W'(p);
        end

        retain = bus.req[rr_ptr] && (credit_eff != '0);
        if (mode_eff == MODE_SP) win_idx = sp_idx;
        else                     win_idx = retain ? rr_ptr : srch_idx;
        win_ok = |bus.req;
`ifdef WRITE_ARB_PKT_LOCK_EN
        if (locked) begin
            win_idx = lock_port;
            win_ok  = bus.req[lock_port];
        end
`endif
        take       = load & win_ok & ~rst;
        win_weight = bus.weight_cfg[win_idx*WEIGHT_W +: WEIGHT_W];
        new_credit = (win_weight == '0) ? '0 : win_weight - 1'b1;
        sel_data   = bus.data_in_p[win_idx*DATA_W +: DATA_W];
        bus.gnt    = take ? (NUM_PORTS'(1) << win_idx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            port_q    <= '0;
            rr_ptr    <= '0;
            credit    <= '0;
            mode_q    <= MODE_SP;
`ifdef WRITE_ARB_PKT_LOCK_EN
            locked    <= 1'b0;
            lock_port <= '0;
`endif
        end else begin
            if (take) begin
                data_q  <= sel_data;
                port_q  <= win_idx;
                valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end

            if (mode_chg) credit <= '0;
`ifdef WRITE_ARB_PKT_LOCK_EN
            if (!locked)
`endif
            mode_q <= mode_cur;

            if (take && mode_eff == MODE_WRR) begin
`ifdef WRITE_ARB_PKT_LOCK_EN
                if (locked)
                    credit <= (credit != '0) ? credit - 1'b1 : '0;
                else
`endif
                if (retain) begin
                    credit <= credit - 1'b1;
                end else begin
                    rr_ptr <= win_idx;
                    credit <= new_credit;
                end
            end
`ifdef WRITE_ARB_PKT_LOCK_EN
            if (take) begin
                locked    <= ~bus.in_last[win_idx];
                lock_port <= win_idx;
            end
`endif
        end
    end

    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_port  = port_q;
endmodule

// File: tb/tb_write_arbiter_wrr.sv
// Self-checking bench for write_arbiter_wrr: vector table, directed corner sequences and a
// randomized run against a reference model. Packet-lock checks build with WRITE_ARB_PKT_LOCK_EN.
module tb_write_arbiter_wrr;
    localparam int DW = 256;
    localparam int NP = 16;
    localparam int WW = 4;
    localparam int PW = 4;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    write_arbiter_wrr_if #(.DATA_W(DW), .NUM_PORTS(NP), .WEIGHT_W(WW), .PORT_ID_W(PW)) bus ();
    write_arbiter_wrr #(.DATA_W(DW), .NUM_PORTS(NP), .WEIGHT_W(WW), .PORT_ID_W(PW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // reference model state
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_port;
    int            m_owner;
    int            m_credit;
    bit            m_mode;
`ifdef WRITE_ARB_PKT_LOCK_EN
    bit            m_locked;
    int            m_lock_port;
`endif

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_port = 0; m_owner = 0; m_credit = 0; m_mode = 0;
`ifdef WRITE_ARB_PKT_LOCK_EN
        m_locked = 0; m_lock_port = 0;
`endif
    endtask

    function automatic int weight_of(int port);
        int w;
        w = int'(bus.weight_cfg[port*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    // winner by the arbitration rules, -1 when nothing is granted
    function automatic int model_pick(input bit wrr, input bit chg, output bit kept);
        int cr;
        kept = 0;
        if (m_valid && !bus.out_ready) return -1;
`ifdef WRITE_ARB_PKT_LOCK_EN
        if (m_locked) return bus.req[m_lock_port] ? m_lock_port : -1;
`endif
        if (bus.req == '0) return -1;
        if (!wrr) begin
            for (int i = 0; i < NP; i++) if (bus.req[i]) return i;
        end
        cr = chg ? 0 : m_credit;
        if (bus.req[m_owner] && cr > 0) begin
            kept = 1;
            return m_owner;
        end
        for (int d = 1; d <= NP; d++) if (bus.req[(m_owner + d) % NP]) return (m_owner + d) % NP;
        return -1;
    endfunction

    task automatic step(output logic [NP-1:0] g_seen);
        int            pick, nw;
        bit            mode, wrr, chg, kept, rdy, lst;
        logic [DW-1:0] pdata;
        logic [NP-1:0] eg;
        @(negedge clk);
        mode = bus.sp0_wrr1;
        rdy  = bus.out_ready;
        wrr  = mode;
        chg  = (mode != m_mode);
        lst  = 1;
`ifdef WRITE_ARB_PKT_LOCK_EN
        if (m_locked) begin wrr = m_mode; chg = 0; end
`endif
        pick  = model_pick(wrr, chg, kept);
        eg    = '0;
        pdata = '0;
        nw    = 0;
        if (pick >= 0) begin
            eg    = NP'(1) << pick;
            pdata = bus.data_in_p[pick*DW +: DW];
            nw    = weight_of(pick) - 1;
`ifdef WRITE_ARB_PKT_LOCK_EN
            lst   = bus.in_last[pick];
`endif
        end
        g_seen = bus.gnt;
        check("gnt", DW'(bus.gnt), DW'(eg));
        @(posedge clk);
        if (pick >= 0) begin m_valid = 1; m_data = pdata; m_port = pick; end
        else if (rdy) m_valid = 0;
        if (chg) m_credit = 0;
`ifdef WRITE_ARB_PKT_LOCK_EN
        if (!m_locked)
`endif
        m_mode = mode;
        if (pick >= 0 && wrr) begin
`ifdef WRITE_ARB_PKT_LOCK_EN
            if (m_locked) m_credit = (m_credit > 0) ? m_credit - 1 : 0;
            else
`endif
            if (kept) m_credit = m_credit - 1;
            else begin m_owner = pick; m_credit = nw; end
        end
`ifdef WRITE_ARB_PKT_LOCK_EN
        if (pick >= 0) begin m_locked = !lst; m_lock_port = pick; end
`endif
        #1;
        check("out_valid", DW'(bus.out_valid), DW'(m_valid));
        check("data_out", bus.data_out, m_data);
        check("out_port", DW'(bus.out_port), DW'(m_port));
    endtask

    task automatic set_pattern();
        for (int i = 0; i < NP; i++) bus.data_in_p[i*DW +: DW] = {8{32'hDA7A_0000 | 32'(i)}};
    endtask

    typedef struct {
        logic [NP-1:0] req;
        logic          rdy;
        logic [NP-1:0] gnt;
        logic          valid;
        int            port;
    } vec_t;

    vec_t          vec[10];
    int            wrr_exp[10];
    int            wrap_exp[4];
    logic [NP-1:0] g;
    logic [DW-1:0] held;

    initial begin
        vec[0] = '{16'h0090, 1'b1, 16'h0010, 1'b1, 4};
        vec[1] = '{16'h0090, 1'b1, 16'h0010, 1'b1, 4};
        vec[2] = '{16'h0080, 1'b1, 16'h0080, 1'b1, 7};
        vec[3] = '{16'h0000, 1'b0, 16'h0000, 1'b1, 7};
        vec[4] = '{16'hFFFF, 1'b0, 16'h0000, 1'b1, 7};
        vec[5] = '{16'hFFFF, 1'b1, 16'h0001, 1'b1, 0};
        vec[6] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 0};
        vec[7] = '{16'h8000, 1'b0, 16'h8000, 1'b1, 15};
        vec[8] = '{16'h8000, 1'b0, 16'h0000, 1'b1, 15};
        vec[9] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 15};
        wrr_exp  = '{0, 0, 0, 1, 2, 0, 0, 0, 1, 2};
        wrap_exp = '{0, 15, 0, 15};

        rst = 1'b0;
        bus.sp0_wrr1 = 1'b0; bus.req = '1; bus.out_ready = 1'b0; bus.weight_cfg = '0;
`ifdef WRITE_ARB_PKT_LOCK_EN
        bus.in_last = '1;
`endif
        set_pattern();
        model_reset();
        #1 rst = 1'b1;
        #11;
        check("rst_gnt", DW'(bus.gnt), '0);
        check("rst_valid", DW'(bus.out_valid), '0);
        check("rst_data", bus.data_out, '0);
        check("rst_port", DW'(bus.out_port), '0);
        bus.req = '0;
        @(posedge clk); #1 rst = 1'b0;

        // strict priority and backpressure vectors
        foreach (vec[i]) begin
            bus.req = vec[i].req;
            bus.out_ready = vec[i].rdy;
            step(g);
            check($sformatf("tbl%0d_gnt", i), DW'(g), DW'(vec[i].gnt));
            check($sformatf("tbl%0d_valid", i), DW'(bus.out_valid), DW'(vec[i].valid));
            check($sformatf("tbl%0d_port", i), DW'(bus.out_port), DW'(vec[i].port));
        end

        // WRR weights 3/1/0 on ports 0/1/2; park the owner on port 2 first
        for (int i = 0; i < NP; i++) bus.weight_cfg[i*WW +: WW] = 4'd1;
        bus.weight_cfg[0 +: WW] = 4'd3;
        bus.weight_cfg[WW +: WW] = 4'd1;
        bus.weight_cfg[2*WW +: WW] = 4'd0;
        bus.sp0_wrr1 = 1'b1; bus.out_ready = 1'b1; bus.req = 16'h0004;
        step(g);
        check("wrr_park", DW'(bus.out_port), DW'(2));
        bus.req = 16'h0007;
        for (int i = 0; i < 10; i++) begin
            step(g);
            check($sformatf("wrr_seq%0d", i), DW'(bus.out_port), DW'(wrr_exp[i]));
        end

        // wrap from port 15 to port 0
        for (int i = 0; i < NP; i++) bus.weight_cfg[i*WW +: WW] = 4'd1;
        bus.req = 16'h8000;
        step(g);
        check("wrap_park", DW'(bus.out_port), DW'(15));
        bus.req = 16'h8001;
        for (int i = 0; i < 4; i++) begin
            step(g);
            check($sformatf("wrap_seq%0d", i), DW'(bus.out_port), DW'(wrap_exp[i]));
        end

        // backpressure: 5 stalled cycles, then drain and grant in one cycle
        held = bus.data_out;
        bus.out_ready = 1'b0; bus.req = '1;
        for (int i = 0; i < 5; i++) begin
            step(g);
            check($sformatf("bp_gnt%0d", i), DW'(g), '0);
            check($sformatf("bp_hold%0d", i), bus.data_out, held);
        end
        bus.out_ready = 1'b1;
        step(g);
        check("bp_release_gnt", DW'(g), DW'(16'h0001));
        check("bp_release_valid", DW'(bus.out_valid), DW'(1));

        // asynchronous reset with a beat pending
        bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_gnt", DW'(bus.gnt), '0);
        check("arst_valid", DW'(bus.out_valid), '0);
        check("arst_data", bus.data_out, '0);
        check("arst_port", DW'(bus.out_port), '0);
        model_reset();
        bus.req = '0;
        @(posedge clk); #1 rst = 1'b0;

`ifdef WRITE_ARB_PKT_LOCK_EN
        // 4-beat packet on port 3 holds off port 0 in SP mode
        bus.sp0_wrr1 = 1'b0; bus.out_ready = 1'b1;
        bus.in_last = '1; bus.in_last[3] = 1'b0;
        bus.req = 16'h0008;
        step(g);
        check("lock_beat0", DW'(g), DW'(16'h0008));
        bus.req = 16'h0009;
        for (int i = 1; i < 4; i++) begin
            if (i == 3) bus.in_last[3] = 1'b1;
            step(g);
            check($sformatf("lock_beat%0d", i), DW'(g), DW'(16'h0008));
        end
        bus.req = 16'h0001;
        step(g);
        check("lock_after", DW'(g), DW'(16'h0001));
`endif

        // randomized run against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) bus.sp0_wrr1 = ~bus.sp0_wrr1;
            if ($urandom_range(0, 99) == 0)
                for (int i = 0; i < NP; i++) bus.weight_cfg[i*WW +: WW] = WW'($urandom);
            bus.req = ($urandom_range(0, 3) == 0) ? NP'(1) << $urandom_range(0, NP - 1)
                                                  : NP'($urandom) & NP'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NP; i++)
                bus.data_in_p[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom,
                                             $urandom, $urandom, $urandom, $urandom};
`ifdef WRITE_ARB_PKT_LOCK_EN
            bus.in_last = NP'($urandom) | NP'($urandom);
`endif
            step(g);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/write_arbiter_wrr.md
Name: write_arbiter_wrr

Overview:
- Parametrised N-port write arbiter; successor to the fixed 16x256 write arbiter.
- Selects one requesting write port per cycle in either strict-priority or weighted-round-robin mode.
- Each input port uses a req/gnt handshake; the output is a registered valid/ready stage with backpressure.
- Sits between the per-port write buffers and the SRAM write controller.

Parameters:
- DATA_W, 256, width of one port's write data.
- NUM_PORTS, 16, number of input ports (>=2).
- WEIGHT_W, 4, width of each per-port WRR weight.
- PORT_ID_W, $clog2(NUM_PORTS), width of the granted-port index.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sp0_wrr1  input  1  mode select: 0 = strict priority, 1 = weighted round robin.
- req  input  NUM_PORTS  per-port request; data held stable while req=1 and gnt=0.
- data_in_p  input  DATA_W*NUM_PORTS  flattened port data; port i occupies bits [i*DATA_W +: DATA_W].
- weight_cfg  input  WEIGHT_W*NUM_PORTS  flattened per-port WRR weights.
- gnt  output  NUM_PORTS  one-hot grant; combinational; port i's beat is consumed on the edge where req[i]&gnt[i].
- data_out  output  DATA_W  registered selected data.
- out_valid  output  1  data_out holds a beat.
- out_ready  input  1  downstream accepts the beat on the edge where out_valid&out_ready.
- out_port  output  PORT_ID_W  index of the port that supplied data_out.

Behaviour:
- Reset (async assert, synchronous-release use): gnt=0, out_valid=0, data_out=0, out_port=0, rr_ptr=0, credit=0.
- Load condition: load = ~out_valid | out_ready. When load=0, gnt=0 and no state changes.
- gnt is one-hot or zero. It is nonzero only when load=1 and at least one req bit is set.
- Latency: a beat granted at edge k appears on data_out/out_valid after edge k, i.e. 1 cycle.
- Output stage: out_valid is set when a grant is taken. It clears on out_ready when no new grant is taken in the same cycle. A simultaneous drain and grant keeps out_valid=1 with the new data.
- SP mode (sp0_wrr1=0): lowest-index requesting port wins. rr_ptr and credit are not updated.
- WRR mode, state: rr_ptr (current owner) and credit counter (WEIGHT_W bits).
- WRR mode, owner retains: if req[rr_ptr] and credit>0, the owner is granted and credit decrements.
- WRR mode, owner yields: otherwise, search circularly from rr_ptr+1 (wrapping NUM_PORTS-1 -> 0) for the first requester. It is granted, rr_ptr moves to it, and credit loads eff_weight-1.
- eff_weight = weight_cfg[i]; a weight of 0 is treated as 1.
- WRR, only the owner requesting with credit=0: the owner is re-granted and credit reloads. The search wraps back to itself.
- WRR, no requests: gnt=0; rr_ptr and credit hold.
- Mode switch: a change of sp0_wrr1 clears credit to 0 on the next edge. rr_ptr is kept, so the first WRR grant after a switch performs a search.
- weight_cfg is sampled only at credit load. Changes mid-turn do not affect the current turn.
- Reset mid-operation: a pending beat in the output register is dropped, and all grants deassert immediately.

Optional Feature:
- Macro: WRITE_ARB_PKT_LOCK_EN.
- Defined: adds input in_last (NUM_PORTS bits, per-port last-beat flag). Once a port is granted a beat with in_last[i]=0, the arbiter is locked to that port. Only that port may be granted, in both modes and ignoring credit, until it is granted a beat with in_last=1. While locked, credit does not decrement below 0 (saturates).
- Defined, mode switch while locked: takes effect after unlock.
- Not defined: in_last does not exist and every beat is arbitrated independently.

Test Plan:
- Reset: assert rst mid-transfer with out_valid=1 -> out_valid=0, gnt=0, data_out=0 immediately, without waiting for an edge.
- SP: req=16'h0090, out_ready=1 -> gnt=16'h0010 every cycle. Port 7 is never granted until req[4] drops, then gnt=16'h0080.
- WRR weights: ports 0/1/2 continuously requesting with weights 3/1/0, out_ready=1 -> out_port sequence 0,0,0,1,2,0,0,0,1,2...
- WRR wrap: ptr=15, req=16'h8001 with weights all 1 -> grants alternate 0,15,0,15...
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> gnt=0, data_out stable. Release out_ready -> one beat drains and the next grant is taken in the same cycle.
- WRITE_ARB_PKT_LOCK_EN defined: port 3 sends a 4-beat packet (last on beat 4) while port 0 requests in SP mode -> all 4 beats from port 3 are granted consecutively, then port 0.
